// File: rtl/gemm_tiled_engine.sv
// Tiled signed GeMM engine: tile-loop controller, A/B address generation, PE array and a ready/valid C write port.
// Build macro GEMM_TILED_ACC_SAT_EN: accumulators saturate instead of wrapping.
module gemm_tiled_engine #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int NumPE_M       = 2,
    parameter int NumPE_N       = 2,
    parameter int NumIp_K       = 16,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        start_i,
    input  logic [SizeAddrWidth-1:0]                    M_tiles_i,
    input  logic [SizeAddrWidth-1:0]                    K_tiles_i,
    input  logic [SizeAddrWidth-1:0]                    N_tiles_i,
    output logic [AddrWidth-1:0]                        sram_a_addr_o,
    output logic [AddrWidth-1:0]                        sram_b_addr_o,
    input  logic [NumPE_M*NumIp_K*InDataWidth-1:0]      sram_a_rdata_i,
    input  logic [NumPE_N*NumIp_K*InDataWidth-1:0]      sram_b_rdata_i,
    output logic [AddrWidth-1:0]                        sram_c_addr_o,
    output logic [NumPE_M*NumPE_N*OutDataWidth-1:0]     sram_c_wdata_o,
    output logic                                        sram_c_we_o,
    input  logic                                        sram_c_ready_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        size_err_o
);
`ifdef GEMM_TILED_ACC_SAT_EN
    localparam int SumWidth = OutDataWidth + $clog2(NumIp_K) + 2;
    localparam logic signed [SumWidth-1:0] SatMax =
        {{(SumWidth-OutDataWidth+1){1'b0}}, {(OutDataWidth-1){1'b1}}};
    localparam logic signed [SumWidth-1:0] SatMin = ~SatMax;
`else
    localparam int SumWidth = OutDataWidth;
`endif
    localparam int ProdWidth = 2 * InDataWidth;
    localparam int LinWidth  = 2 * SizeAddrWidth;
    localparam int CWidth    = NumPE_M * NumPE_N * OutDataWidth;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_LAST, S_WRITE, S_DONE} state_t;

    state_t                   r_state, w_state_next;
    logic [SizeAddrWidth-1:0] r_m_t, r_k_t, r_n_t;
    logic [SizeAddrWidth-1:0] r_m, r_n, r_k;
    logic                     r_acc_en, r_first, r_size_err;
    logic [AddrWidth-1:0]     r_a_addr, r_b_addr, r_c_addr;
    logic [CWidth-1:0]        r_c_wdata;
    logic [CWidth-1:0]        w_acc_flat;
    logic [LinWidth-1:0]      w_a_lin, w_b_lin, w_c_lin;
    logic [AddrWidth-1:0]     w_a_addr, w_b_addr, w_c_addr;
    logic                     w_zero_size, w_last_k, w_last_n, w_last_tile;

    assign w_zero_size = (M_tiles_i == '0) || (K_tiles_i == '0) || (N_tiles_i == '0);
    assign w_last_k    = (r_k == r_k_t - SizeAddrWidth'(1));
    assign w_last_n    = (r_n == r_n_t - SizeAddrWidth'(1));
    assign w_last_tile = w_last_n && (r_m == r_m_t - SizeAddrWidth'(1));

    assign w_a_lin  = LinWidth'(r_m) * LinWidth'(r_k_t) + LinWidth'(r_k);
    assign w_b_lin  = LinWidth'(r_k) * LinWidth'(r_n_t) + LinWidth'(r_n);
    assign w_c_lin  = LinWidth'(r_m) * LinWidth'(r_n_t) + LinWidth'(r_n);
    assign w_a_addr = AddrWidth'(w_a_lin);
    assign w_b_addr = AddrWidth'(w_b_lin);
    assign w_c_addr = AddrWidth'(w_c_lin);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = w_zero_size ? S_DONE : S_RUN;
            S_RUN:   if (w_last_k) w_state_next = S_LAST;
            S_LAST:  w_state_next = S_WRITE;
            S_WRITE: if (sram_c_ready_i) w_state_next = w_last_tile ? S_DONE : S_RUN;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counters, latched sizes and the hold registers behind the address/data outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m_t <= '0; r_k_t <= '0; r_n_t <= '0;
            r_m <= '0; r_n <= '0; r_k <= '0;
            r_acc_en <= 1'b0; r_first <= 1'b0; r_size_err <= 1'b0;
            r_a_addr <= '0; r_b_addr <= '0; r_c_addr <= '0; r_c_wdata <= '0;
        end else begin
            r_acc_en <= (r_state == S_RUN);
            r_first  <= (r_state == S_RUN) && (r_k == '0);
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_m_t <= M_tiles_i; r_k_t <= K_tiles_i; r_n_t <= N_tiles_i;
                    r_m <= '0; r_n <= '0; r_k <= '0;
                    r_size_err <= w_zero_size;
                end
                S_RUN: begin
                    r_a_addr <= w_a_addr;
                    r_b_addr <= w_b_addr;
                    r_k      <= w_last_k ? '0 : r_k + SizeAddrWidth'(1);
                end
                S_WRITE: begin
                    r_c_addr  <= w_c_addr;
                    r_c_wdata <= w_acc_flat;
                    if (sram_c_ready_i) begin
                        if (w_last_n) begin
                            r_n <= '0;
                            r_m <= r_m + SizeAddrWidth'(1);
                        end else begin
                            r_n <= r_n + SizeAddrWidth'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NumPE_M; gi++) begin : g_row
            for (gj = 0; gj < NumPE_N; gj++) begin : g_col
                logic signed [ProdWidth-1:0]    w_prod;
                logic signed [SumWidth-1:0]     w_sum;
                logic signed [OutDataWidth-1:0] w_res;
                logic signed [OutDataWidth-1:0] r_acc;

                // First k of a tile loads instead of accumulating, so no clear cycle is needed.
                always_comb begin
                    w_prod = '0;
                    w_sum  = r_first ? '0 : SumWidth'(r_acc);
                    for (int kk = 0; kk < NumIp_K; kk++) begin
                        w_prod = ProdWidth'($signed(sram_a_rdata_i[(gi*NumIp_K+kk)*InDataWidth +: InDataWidth]))
                               * ProdWidth'($signed(sram_b_rdata_i[(gj*NumIp_K+kk)*InDataWidth +: InDataWidth]));
                        w_sum  = w_sum + SumWidth'(w_prod);
                    end
                end

`ifdef GEMM_TILED_ACC_SAT_EN
                always_comb begin
                    if (w_sum > SatMax)      w_res = SatMax[OutDataWidth-1:0];
                    else if (w_sum < SatMin) w_res = SatMin[OutDataWidth-1:0];
                    else                     w_res = w_sum[OutDataWidth-1:0];
                end
`else
                assign w_res = w_sum;
`endif

                always_ff @(posedge clk_i) begin
                    if (rst_i)         r_acc <= '0;
                    else if (r_acc_en) r_acc <= w_res;
                end

                assign w_acc_flat[(gi*NumPE_N+gj)*OutDataWidth +: OutDataWidth] = r_acc;
            end
        end
    endgenerate

    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = (r_state == S_DONE);
    assign sram_c_we_o    = (r_state == S_WRITE);
    assign sram_a_addr_o  = (r_state == S_RUN)   ? w_a_addr   : r_a_addr;
    assign sram_b_addr_o  = (r_state == S_RUN)   ? w_b_addr   : r_b_addr;
    assign sram_c_addr_o  = (r_state == S_WRITE) ? w_c_addr   : r_c_addr;
    assign sram_c_wdata_o = (r_state == S_WRITE) ? w_acc_flat : r_c_wdata;
    assign size_err_o     = r_size_err;

endmodule

// File: tb/tb_gemm_tiled_engine.sv
// Randomized self-checking bench for gemm_tiled_engine (OutDataWidth=16) against a tile-level arithmetic model.
module tb_gemm_tiled_engine;
    localparam int IW = 8, OW = 16, PM = 2, PN = 2, PK = 16, AW = 16, SW = 8;
    localparam int AWID = PM*PK*IW, BWID = PN*PK*IW, CW = PM*PN*OW;
    localparam longint SMAX = (longint'(1) << (OW-1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    logic            clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
    logic [SW-1:0]   m_tiles = '0, k_tiles = '0, n_tiles = '0;
    logic [AW-1:0]   a_addr, b_addr, c_addr;
    logic [AWID-1:0] a_rdata = '0;
    logic [BWID-1:0] b_rdata = '0;
    logic [CW-1:0]   c_wdata;
    logic            c_we, c_ready = 1'b1, busy, done, size_err;

    logic [AWID-1:0] mem_a [64];
    logic [BWID-1:0] mem_b [64];

    int  checks = 0, failures = 0, cyc = 0, t0 = 0;
    bit  active = 0, job_done = 0, no_write = 0, prev_stall = 0, rand_rdy = 0;
    int  stall_left = 0, stalls = 0, writes = 0, first_we_cyc = -1, first_len = 0;
    int  done_base = 0, last_done_cyc = -1;
    logic [AW-1:0] exp_addr_q[$];
    logic [CW-1:0] exp_data_q[$];
    logic [AW-1:0] prev_addr = '0;
    logic [CW-1:0] prev_data = '0;

    gemm_tiled_engine #(.InDataWidth(IW), .OutDataWidth(OW), .NumPE_M(PM), .NumPE_N(PN),
                        .NumIp_K(PK), .AddrWidth(AW), .SizeAddrWidth(SW)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .M_tiles_i(m_tiles), .K_tiles_i(k_tiles), .N_tiles_i(n_tiles),
        .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr),
        .sram_a_rdata_i(a_rdata), .sram_b_rdata_i(b_rdata),
        .sram_c_addr_o(c_addr), .sram_c_wdata_o(c_wdata), .sram_c_we_o(c_we),
        .sram_c_ready_i(c_ready), .busy_o(busy), .done_o(done), .size_err_o(size_err)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // 1-cycle-latency SRAM models
    always @(posedge clk_i) begin
        a_rdata <= mem_a[a_addr[5:0]];
        b_rdata <= mem_b[b_addr[5:0]];
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One C tile straight from the definition: per K-tile, base + dot product, then wrap or clamp.
    function automatic logic [CW-1:0] model_tile(input int m, input int n, input int kt, input int nt);
        logic [CW-1:0]   r;
        logic [AWID-1:0] aw;
        logic [BWID-1:0] bw;
        logic [OW-1:0]   lo;
        longint          acc, s;
        r = '0;
        for (int i = 0; i < PM; i++) begin
            for (int j = 0; j < PN; j++) begin
                acc = 0;
                for (int t = 0; t < kt; t++) begin
                    aw = mem_a[(m*kt+t) % 64];
                    bw = mem_b[(t*nt+n) % 64];
                    s  = acc;
                    for (int k = 0; k < PK; k++)
                        s += longint'($signed(aw[(i*PK+k)*IW +: IW])) * longint'($signed(bw[(j*PK+k)*IW +: IW]));
`ifdef GEMM_TILED_ACC_SAT_EN
                    acc = (s > SMAX) ? SMAX : ((s < SMIN) ? SMIN : s);
`else
                    lo  = s[OW-1:0];
                    acc = longint'($signed(lo));
`endif
                end
                lo = acc[OW-1:0];
                r[(i*PN+j)*OW +: OW] = lo;
            end
        end
        return r;
    endfunction

    task automatic fill(input bit rnd, input logic [7:0] av, input logic [7:0] bv);
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < AWID/8; b++) mem_a[a][b*8 +: 8] = rnd ? 8'($urandom) : av;
            for (int b = 0; b < BWID/8; b++) mem_b[a][b*8 +: 8] = rnd ? 8'($urandom) : bv;
        end
    endtask

    // Single compare process: drives ready, checks every write cycle and the done pulse.
    always @(negedge clk_i) begin
        if (active) begin
            if (c_we && stall_left > 0) begin
                c_ready = 1'b0;
                stall_left--;
            end else if (rand_rdy) c_ready = 1'($urandom_range(0, 1));
            else                   c_ready = 1'b1;
            if (c_we) begin
                if (first_we_cyc < 0) first_we_cyc = cyc - t0;
                if (writes == 0) first_len++;
                if (prev_stall) begin
                    chk("hold_addr", CW'(c_addr), CW'(prev_addr));
                    chk("hold_data", c_wdata, prev_data);
                end
                if (exp_addr_q.size() == 0) chk("unexpected_write", CW'(c_we), '0);
                else begin
                    chk("c_addr", CW'(c_addr), CW'(exp_addr_q[0]));
                    chk("c_data", c_wdata, exp_data_q[0]);
                end
                if (c_ready) begin
                    $display("write addr=%0d data=%h cycle=%0d", c_addr, c_wdata, cyc - t0);
                    writes++;
                    prev_stall = 0;
                    if (exp_addr_q.size() > 0) begin
                        void'(exp_addr_q.pop_front());
                        void'(exp_data_q.pop_front());
                    end
                end else begin
                    stalls++;
                    prev_stall = 1;
                    prev_addr  = c_addr;
                    prev_data  = c_wdata;
                end
            end else if (prev_stall) begin
                chk("we_held", CW'(c_we), CW'(1));
                prev_stall = 0;
            end
            if (done) begin
                chk("done_cycle", CW'(cyc - t0), CW'(done_base + stalls));
                last_done_cyc = cyc - t0;
                job_done = 1;
            end
        end
        if (no_write && c_we) chk("no_write", CW'(c_we), '0);
    end

    task automatic run_job(input int mt, input int kt, input int nt, input int stall_first,
                           input bit rnd, input bit extra);
        for (int m = 0; m < mt; m++)
            for (int n = 0; n < nt; n++) begin
                exp_addr_q.push_back(AW'(m*nt+n));
                exp_data_q.push_back(model_tile(m, n, kt, nt));
            end
        m_tiles = SW'(mt); k_tiles = SW'(kt); n_tiles = SW'(nt);
        stall_left = stall_first; rand_rdy = rnd; stalls = 0; writes = 0;
        first_we_cyc = -1; first_len = 0; prev_stall = 0; job_done = 0;
        done_base = 1 + mt*nt*(kt+2);
        start_i = 1'b1; t0 = cyc; active = 1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_c1", CW'(busy), CW'(1));
        chk("size_err_c1", CW'(size_err), '0);
        for (int c = 0; c < 5000 && !job_done; c++) begin
            start_i = extra && ((cyc - t0) == 3);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        chk("job_finished", CW'(job_done), CW'(1));
        active = 0; c_ready = 1'b1;
        chk("write_count", CW'(writes), CW'(mt*nt));
        chk("queue_empty", CW'(exp_addr_q.size()), '0);
        exp_addr_q.delete(); exp_data_q.delete();
        @(negedge clk_i);
        chk("busy_after", CW'(busy), '0);
    endtask

    task automatic zero_size_test();
        logic [AW-1:0] a0;
        a0 = a_addr; no_write = 1;
        m_tiles = 2; k_tiles = 0; n_tiles = 2; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("zs_done_c1", CW'(done), CW'(1));
        chk("zs_err_c1", CW'(size_err), CW'(1));
        @(negedge clk_i);
        chk("zs_done_c2", CW'(done), '0);
        chk("zs_busy_c2", CW'(busy), '0);
        repeat (4) @(negedge clk_i);
        chk("zs_err_sticky", CW'(size_err), CW'(1));
        chk("zs_a_addr", CW'(a_addr), CW'(a0));
        no_write = 0;
    endtask

    task automatic reset_test();
        int bad;
        bad = 0;
        m_tiles = 2; k_tiles = 2; n_tiles = 2; start_i = 1'b1; no_write = 1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_ctl", CW'({busy, done, c_we, size_err}), '0);
        chk("rst_addr", CW'({a_addr, b_addr, c_addr}), '0);
        chk("rst_wdata", c_wdata, '0);
        rst_i = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (busy || done) bad++;
        end
        chk("rst_stays_idle", CW'(bad), '0);
        no_write = 0;
    endtask

    initial begin
        fill(1, 8'h00, 8'h00);
        repeat (3) @(negedge clk_i);
        chk("reset_ctl", CW'({busy, done, c_we, size_err}), '0);
        chk("reset_addr", CW'({a_addr, b_addr, c_addr}), '0);
        chk("reset_wdata", c_wdata, '0);
        rst_i = 1'b0;
        @(negedge clk_i);

        fill(0, 8'd2, 8'd3);
        chk("model_pin_96", model_tile(0, 0, 1, 1), {4{16'd96}});
        run_job(1, 1, 1, 0, 0, 0);
        chk("t1_first_write_cycle", CW'(first_we_cyc), CW'(3));
        chk("t1_done_cycle", CW'(last_done_cyc), CW'(4));

        fill(1, 8'h00, 8'h00);
        run_job(2, 3, 2, 0, 0, 1);

        fill(1, 8'h00, 8'h00);
        run_job(2, 2, 2, 3, 0, 0);
        chk("bp_first_write_len", CW'(first_len), CW'(4));

        fill(1, 8'h00, 8'h00);
        run_job(3, 2, 2, 0, 1, 0);

        zero_size_test();
        fill(1, 8'h00, 8'h00);
        run_job(1, 2, 3, 0, 0, 0);

        fill(0, 8'h80, 8'h80);
`ifdef GEMM_TILED_ACC_SAT_EN
        chk("model_pin_neg128", model_tile(0, 0, 1, 1), {4{16'h7FFF}});
`else
        chk("model_pin_neg128", model_tile(0, 0, 1, 1), {4{16'h0000}});
`endif
        run_job(1, 1, 1, 0, 0, 0);

        fill(1, 8'h00, 8'h00);
        reset_test();
        run_job(2, 1, 1, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
